// File: rtl/sobel_edge_stream.sv
// Streaming 3x3 Sobel edge filter with internal line buffers.
// Fixed three-clock latency from accepted pixel to registered result.
module sobel_edge_stream #(
    parameter int DATA_W     = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic              sof_in,
    input  logic [DATA_W-1:0] pixel_data,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] threshold,
    output logic              valid_out,
    output logic [DATA_W-1:0] edge_data,
    output logic              eof_out,
    output logic              frame_err
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int GW = DATA_W + 3;
    localparam int MW = DATA_W + 4;
    localparam logic [CW-1:0] CMAX = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] RMAX = RW'(IMG_HEIGHT - 1);
    localparam logic [MW-1:0] SATV = MW'({DATA_W{1'b1}});

    logic [CW-1:0]     col_q, col_d, pcol;
    logic [RW-1:0]     row_q, row_d, prow;
    logic              err_d;
    logic              s0_v_q, s0_out_q, s0_eof_q;
    logic [DATA_W-1:0] s0_pix_q;
    logic [CW-1:0]     s0_col_q;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] thr_q;
    logic              frame_err_q;

    // Position of this beat: sof forces the frame origin.
    always_comb begin
        pcol  = sof_in ? '0 : col_q;
        prow  = sof_in ? '0 : row_q;
        err_d = valid_in && sof_in && (col_q != '0 || row_q != '0);
        col_d = col_q;
        row_d = row_q;
        if (valid_in) begin
            if (pcol == CMAX) begin
                col_d = '0;
                row_d = (prow == RMAX) ? '0 : prow + RW'(1);
            end else begin
                col_d = pcol + CW'(1);
                row_d = prow;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            s0_v_q      <= 1'b0;
            s0_out_q    <= 1'b0;
            s0_eof_q    <= 1'b0;
            s0_pix_q    <= '0;
            s0_col_q    <= '0;
            mode_q      <= '0;
            thr_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            s0_v_q      <= valid_in;
            s0_out_q    <= valid_in && prow >= RW'(2) && pcol >= CW'(2);
            s0_eof_q    <= prow == RMAX && pcol == CMAX;
            s0_pix_q    <= pixel_data;
            s0_col_q    <= pcol;
            frame_err_q <= err_d;
            if (valid_in && sof_in) begin
                mode_q <= mode;
                thr_q  <= threshold;
            end
        end
    end

    logic [DATA_W-1:0] lb0_q [IMG_WIDTH];
    logic [DATA_W-1:0] lb1_q [IMG_WIDTH];
    logic [DATA_W-1:0] win_q [9];
    logic [DATA_W-1:0] lb0_rd, lb1_rd;

    assign lb0_rd = lb0_q[s0_col_q];
    assign lb1_rd = lb1_q[s0_col_q];

    // lb1 holds the previous line, lb0 the one before it.
    always_ff @(posedge clk) begin
        if (s0_v_q) begin
            lb1_q[s0_col_q] <= s0_pix_q;
            lb0_q[s0_col_q] <= lb1_rd;
            win_q[0] <= win_q[1];
            win_q[1] <= win_q[2];
            win_q[2] <= lb0_rd;
            win_q[3] <= win_q[4];
            win_q[4] <= win_q[5];
            win_q[5] <= lb1_rd;
            win_q[6] <= win_q[7];
            win_q[7] <= win_q[8];
            win_q[8] <= s0_pix_q;
        end
    end

    logic              s1_v_q, s1_eof_q;
    logic [1:0]        s1_mode_q;
    logic [DATA_W-1:0] s1_thr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q    <= 1'b0;
            s1_eof_q  <= 1'b0;
            s1_mode_q <= '0;
            s1_thr_q  <= '0;
        end else begin
            s1_v_q    <= s0_v_q && s0_out_q;
            s1_eof_q  <= s0_eof_q;
            s1_mode_q <= mode_q;
            s1_thr_q  <= thr_q;
        end
    end

    logic signed [GW-1:0] px [9];
    logic signed [GW-1:0] gx_d, gy_d, gx_q, gy_q;

    always_comb begin
        for (int i = 0; i < 9; i++) begin
            px[i] = signed'({3'b000, win_q[i]});
        end
        gx_d = (px[2] + (px[5] <<< 1) + px[8])
             - (px[0] + (px[3] <<< 1) + px[6]);
        gy_d = (px[6] + (px[7] <<< 1) + px[8])
             - (px[0] + (px[1] <<< 1) + px[2]);
    end

    logic              s2_v_q, s2_eof_q;
    logic [1:0]        s2_mode_q;
    logic [DATA_W-1:0] s2_thr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            gx_q      <= '0;
            gy_q      <= '0;
            s2_v_q    <= 1'b0;
            s2_eof_q  <= 1'b0;
            s2_mode_q <= '0;
            s2_thr_q  <= '0;
        end else begin
            gx_q      <= gx_d;
            gy_q      <= gy_d;
            s2_v_q    <= s1_v_q;
            s2_eof_q  <= s1_eof_q;
            s2_mode_q <= s1_mode_q;
            s2_thr_q  <= s1_thr_q;
        end
    end

    logic [GW-1:0]     ax, ay;
    logic [MW-1:0]     mag, axw, ayw;
    logic [DATA_W-1:0] res_d;

    always_comb begin
        ax    = gx_q[GW-1] ? GW'(-gx_q) : GW'(gx_q);
        ay    = gy_q[GW-1] ? GW'(-gy_q) : GW'(gy_q);
        axw   = MW'(ax);
        ayw   = MW'(ay);
        mag   = axw + ayw;
        res_d = '0;
        unique case (s2_mode_q)
            2'd0: res_d = (mag > MW'(s2_thr_q)) ? '1 : '0;
            2'd1: res_d = (mag > SATV) ? '1 : mag[DATA_W-1:0];
            2'd2: res_d = (axw > SATV) ? '1 : axw[DATA_W-1:0];
            2'd3: res_d = (ayw > SATV) ? '1 : ayw[DATA_W-1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            edge_data <= '0;
            eof_out   <= 1'b0;
        end else begin
            valid_out <= s2_v_q;
            edge_data <= s2_v_q ? res_d : '0;
            eof_out   <= s2_v_q && s2_eof_q;
        end
    end

    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_sobel_edge_stream.sv
// Randomised self-checking bench for sobel_edge_stream on a 4x4 image.
// Reference keeps the received frame in an array and convolves directly.
module tb_sobel_edge_stream;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;

    logic          clk = 1'b0;
    logic          rst, valid_in, sof_in;
    logic [DW-1:0] pixel_data, threshold, edge_data;
    logic [1:0]    mode;
    logic          valid_out, eof_out, frame_err;

    sobel_edge_stream #(.DATA_W(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .sof_in    (sof_in),
        .pixel_data(pixel_data),
        .mode      (mode),
        .threshold (threshold),
        .valid_out (valid_out),
        .edge_data (edge_data),
        .eof_out   (eof_out),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int due;
        int d;
        bit e;
    } exp_t;

    exp_t q[$];
    int   img [H][W];
    int   pr, pc, mmode, mthr, err_due;
    bit   rst_prev;
    int   n_chk, n_fail;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d",
                     tag, cyc, got, exp);
        end
    endtask

    function automatic int sat(int v);
        return (v > 255) ? 255 : v;
    endfunction

    function automatic int ref_out(int r, int c);
        int p [9];
        int gx, gy, ax, ay, mag;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                p[i*3+j] = img[r-2+i][c-2+j];
        gx  = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
        gy  = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
        ax  = (gx < 0) ? -gx : gx;
        ay  = (gy < 0) ? -gy : gy;
        mag = ax + ay;
        case (mmode)
            0:       return (mag > mthr) ? 255 : 0;
            1:       return sat(mag);
            2:       return sat(ax);
            default: return sat(ay);
        endcase
    endfunction

    task automatic tick(bit r, bit v, bit s, int p, int m, int t);
        bit   ev;
        exp_t e;
        @(negedge clk);
        ev = (q.size() > 0) && (q[0].due == cyc);
        check("valid_out", valid_out, ev);
        if (ev) begin
            check("edge_data", edge_data, q[0].d);
            check("eof_out", eof_out, q[0].e);
            void'(q.pop_front());
        end else begin
            if (q.size() > 0 && q[0].due < cyc) begin
                check("late_out", q[0].due, cyc);
                void'(q.pop_front());
            end
            check("eof_idle", eof_out, 1'b0);
        end
        check("frame_err", frame_err, err_due == cyc);
        if (rst_prev) check("rst_data", edge_data, 0);
        rst        = r;
        valid_in   = v;
        sof_in     = s;
        pixel_data = DW'(p);
        mode       = 2'(m);
        threshold  = DW'(t);
        rst_prev   = r;
        if (r) begin
            q.delete();
            pr = 0; pc = 0; mmode = 0; mthr = 0;
        end else if (v) begin
            if (s) begin
                if (pr != 0 || pc != 0) err_due = cyc + 1;
                pr = 0; pc = 0; mmode = m; mthr = t;
            end
            img[pr][pc] = p;
            if (pr >= 2 && pc >= 2) begin
                e.due = cyc + 4;
                e.d   = ref_out(pr, pc);
                e.e   = (pr == H-1) && (pc == W-1);
                q.push_back(e);
            end
            pc++;
            if (pc == W) begin
                pc = 0;
                pr = (pr == H-1) ? 0 : pr + 1;
            end
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++)
            tick(0, 0, 1'($urandom_range(0, 1)), $urandom_range(0, 255),
                 $urandom_range(0, 3), $urandom_range(0, 255));
    endtask

    task automatic frame(int kind, int m, int t, int gap, bit sof,
                         int npix = W*H);
        int  c, p;
        bit  first;
        for (int i = 0; i < npix; i++) begin
            c = i % W;
            first = (i == 0);
            case (kind)
                0:       p = (c < 2) ? 50 : 200;
                1:       p = 10 * c;
                2:       p = 100;
                default: p = $urandom_range(0, 255);
            endcase
            if (first && sof)
                tick(0, 1, 1, p, m, t);
            else
                tick(0, 1, 0, p, $urandom_range(0, 3),
                     $urandom_range(0, 255));
            if (gap == 1) idle(1);
            if (gap == 2 && $urandom_range(0, 2) == 0)
                idle($urandom_range(1, 3));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1; valid_in = 0; sof_in = 0; pixel_data = 0;
        mode = 0; threshold = 0;
        pr = 0; pc = 0; mmode = 0; mthr = 0; err_due = -1;
        rst_prev = 1; n_chk = 0; n_fail = 0;
        tick(1, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        frame(3, 0, 0, 0, 0);
        idle(5);
        frame(0, 1, 0, 0, 1);
        idle(4);
        frame(0, 2, 0, 0, 1);
        frame(0, 3, 0, 0, 1);
        frame(0, 0, 100, 0, 1);
        idle(3);
        frame(1, 1, 0, 0, 1);
        frame(1, 0, 80, 0, 1);
        frame(1, 0, 79, 0, 1);
        idle(3);
        frame(2, 0, 0, 0, 1);
        frame(2, 0, 0, 1, 1);
        idle(4);
        frame(3, 1, 0, 0, 1, 6);
        frame(3, 1, 0, 0, 1);
        idle(5);
        frame(3, 1, 0, 0, 1, 13);
        tick(1, 0, 0, 0, 0, 0);
        frame(3, 1, 0, 0, 1);
        idle(5);
        for (int k = 0; k < 40; k++) begin
            frame(3, $urandom_range(0, 3), $urandom_range(0, 255),
                  $urandom_range(0, 2), 1'($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 5) == 0) ? $urandom_range(1, 15) : W*H);
            if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 4));
        end
        idle(8);
        check("drain", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sobel_edge_stream.md
Name: sobel_edge_stream

Overview:
- Parametrised streaming 3x3 Sobel edge filter for raster-ordered grey pixels. Next generation of the existing single-window Sobel detector.
- Adds:
  - internal line buffers for full-frame operation;
  - configurable pixel width and image size;
  - a runtime output mode and a runtime threshold;
  - frame-start resynchronisation and an error flag.
- Sits between the pixel source (camera/DMA) and the downstream edge consumer.

Parameters:
- DATA_W, 8, pixel and output width in bits.
- IMG_WIDTH, 640, pixels per line (>=3).
- IMG_HEIGHT, 480, lines per frame (>=3).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- valid_in  in  1  pixel_data and sof_in are valid this cycle. No backpressure: every valid beat is accepted.
- sof_in  in  1  first pixel of a frame; qualified by valid_in.
- pixel_data  in  DATA_W  input pixel, raster order.
- mode  in  2  output mode: 0 binary, 1 magnitude, 2 |Gx| only, 3 |Gy| only.
- threshold  in  DATA_W  binary-mode threshold.
- valid_out  out  1  edge_data is valid.
- edge_data  out  DATA_W  filtered output.
- eof_out  out  1  with valid_out; marks the last interior output of the frame.
- frame_err  out  1  one-cycle pulse on a misplaced sof_in.

Behaviour:
- Reset: all outputs 0.
  - Row counter, column counter, valid pipeline and latched mode/threshold are cleared (mode=0, threshold=0).
  - Line-buffer RAM is not cleared; rows 0-1 are rewritten before use.
  - Reset mid-frame abandons the frame; no stale valid_out appears after reset deasserts.
- Counters:
  - col advances on each accepted beat and wraps at IMG_WIDTH-1 to 0, advancing row.
  - row wraps at IMG_HEIGHT-1 to 0.
  - Gaps in valid_in freeze the counters and line buffers.
- sof_in:
  - An accepted beat with sof_in=1 forces that pixel to position (0,0) and latches mode and threshold.
  - If the counters were not at (0,0), frame_err pulses for 1 cycle (registered, one cycle after the beat) and the frame restarts.
  - The first frame after reset need not carry sof_in; it is treated as starting at (0,0).
- Line buffers: two IMG_WIDTH-deep buffers of DATA_W bits hold the previous two lines. Together with a 3x3 register window this forms p0..p8, row-major, p0 = top-left (oldest).
- Output generation:
  - An accepted beat at (r,c) with r>=2 and c>=2 produces exactly one output, for centre pixel (r-1,c-1).
  - Border pixels produce no output; each frame yields (IMG_HEIGHT-2)*(IMG_WIDTH-2) outputs.
  - eof_out accompanies the output triggered by input (IMG_HEIGHT-1, IMG_WIDTH-1).
- Latency: fixed 3 clocks. If the beat is sampled at edge N, valid_out/edge_data/eof_out are registered at edge N+3.
  - Pipeline stage 1: window update.
  - Stage 2: Gx, Gy.
  - Stage 3: magnitude/mode.
  - Back-to-back beats give back-to-back outputs.
- Arithmetic:
  - Gx = (p2+2p5+p8)-(p0+2p3+p6); Gy = (p6+2p7+p8)-(p0+2p1+p2).
  - Both are signed, DATA_W+3 bits, with no overflow.
  - mag = |Gx|+|Gy|, unsigned, DATA_W+4 bits.
- Mode results (mode latched at sof):
  - Mode 0: edge_data = all-ones if mag > threshold, else 0 (strictly greater).
  - Mode 1: mag saturated to 2^DATA_W-1.
  - Mode 2: |Gx| saturated.
  - Mode 3: |Gy| saturated.
- Simultaneous events:
  - If sof_in arrives while pipeline outputs are in flight, those outputs still emerge unchanged with their original mode.
  - The new mode applies only to windows completed after the sof beat.

Test Plan:
- IMG 4x4, mode 1, sof on first pixel, every row = 50,50,200,200 -> 4 outputs, all 255 (mag 600 saturated); eof_out on 4th; first valid_out 3 clocks after input (2,2).
- Same image, mode 2 -> 255 x4; mode 3 -> 0 x4; mode 0 with threshold 100 -> 255 x4.
- Horizontal ramp pixel = 10*c (0,10,20,30 per row), mode 1 -> 80 x4; mode 0 threshold 80 -> 0 x4; threshold 79 -> 255 x4.
- Uniform 100 frame, mode 0 threshold 0 -> 0 x4 (strict compare); valid_in toggled every other cycle -> same 4 outputs, each 3 clocks after its trigger beat.
- sof_in at pixel (1,2) of a frame -> frame_err single pulse; counters restart; the following full 4x4 frame yields exactly 4 outputs with correct eof_out.
- rst asserted at pixel (3,1) -> all outputs 0 next edge; no valid_out from the abandoned frame; the next full frame yields the correct 4 outputs.
